uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake, transmitter drive and status signals of uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          uart_start;
    logic [DATA_WIDTH-1:0]         uart_data;
    logic                          uart_busy;
    logic [IW-1:0]                 grant_id;
    logic                          arb_busy;
    logic                          timeout_err;
    modport slave (
        input  req_valid, req_data, uart_busy,
        output req_ready, uart_start, uart_data, grant_id, arb_busy, timeout_err
    );
    modport master (
        output req_valid, req_data, uart_busy,
        input  req_ready, uart_start, uart_data, grant_id, arb_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; define UART_ARB_TIMEOUT_EN for a sticky start-to-busy timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, GRANT, START, WAIT_DONE} state_t;
    state_t                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, grant_q, grant_d, pick, idx;
    logic [IW:0]           sum;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            sync_q;
    logic                  busy_s, timeout;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    assign busy_s = sync_q[1];

    // Walk offsets high to low so the requester closest above the pointer wins.
    always_comb begin
        pick = ptr_q;
        sum  = '0;
        idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            idx = IW'(sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum);
            if (bus.req_valid[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                grant_d = |bus.req_valid ? pick : grant_q;
                state_d = |bus.req_valid ? GRANT : IDLE;
            end
            GRANT: begin
                data_d  = bus.req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
                ptr_d   = grant_q == IW'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d = START;
            end
            START:     state_d = busy_s ? WAIT_DONE : (timeout ? IDLE : START);
            WAIT_DONE: state_d = busy_s ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            sync_q  <= {sync_q[0], bus.uart_busy};
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d   = state_q == START ? cnt_q + 1'b1 : '0;
        timeout = state_q == START && !busy_s && cnt_q == CW'(TIMEOUT_CYCLES);
        err_d   = err_q | timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign timeout         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.req_ready  = state_q == GRANT ? NUM_REQ'(1) << grant_q : '0;
    assign bus.uart_start = state_q == START;
    assign bus.uart_data  = data_q;
    assign bus.grant_id   = grant_q;
    assign bus.arb_busy   = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a transfer-level reference model compared on every falling edge
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 100;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int rise_delay = 2;
    int busy_len = 8;
    bit tx_en = 1'b1;
    int grants[$];
    int starts[$];
    bit prev_start = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int rr_pick(logic [NR-1:0] v, int p);
        for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
        return p;
    endfunction

    function automatic int g(int i);
        return i < grants.size() ? grants[i] : -1;
    endfunction

    function automatic int s(int i);
        return i < starts.size() ? starts[i] : -1;
    endfunction

    // Reference model: phase 0 idle, 1 accepting, 2 asking the transmitter, 3 draining.
    int m_phase = 0;
    int m_gid = 0;
    int m_ptr = 0;
    int m_wait = 0;
    logic [DW-1:0] m_data = '0;
    bit m_err = 1'b0;
    bit [1:0] m_sync = 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_gid   <= 0;
            m_ptr   <= 0;
            m_wait  <= 0;
            m_data  <= '0;
            m_err   <= 1'b0;
            m_sync  <= 2'b00;
        end else begin
            m_sync <= {m_sync[0], bus.uart_busy};
            if (m_phase == 0 && |bus.req_valid) begin
                m_gid   <= rr_pick(bus.req_valid, m_ptr);
                m_phase <= 1;
            end
            if (m_phase == 1) begin
                m_data  <= bus.req_data[m_gid*DW +: DW];
                m_ptr   <= (m_gid + 1) % NR;
                m_wait  <= 0;
                m_phase <= 2;
            end
            if (m_phase == 2) begin
                if (m_sync[1]) m_phase <= 3;
                else if (TO_EN && m_wait == TO) begin
                    m_phase <= 0;
                    m_err   <= 1'b1;
                end else m_wait <= m_wait + 1;
            end
            if (m_phase == 3 && !m_sync[1]) m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("req_ready", bus.req_ready, m_phase == 1 ? 32'(1) << m_gid : 32'd0);
        check("uart_start", bus.uart_start, m_phase == 2);
        check("uart_data", bus.uart_data, m_data);
        check("grant_id", bus.grant_id, m_gid);
        check("arb_busy", bus.arb_busy, m_phase != 0);
        check("timeout_err", bus.timeout_err, m_err);
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) grants.push_back(i);
        if (bus.uart_start && !prev_start) starts.push_back(int'(bus.uart_data));
        prev_start <= bus.uart_start;
    end

    initial begin
        bus.uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && bus.uart_start) begin
                repeat (rise_delay) @(posedge clk);
                #1 bus.uart_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.uart_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int c = 0;
        while (grants.size() < n && c < 3000) begin
            tick();
            c++;
        end
        check("grant_count", grants.size(), n);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((bus.arb_busy || bus.uart_busy) && c < 3000) begin
            tick();
            c++;
        end
        check("idle", bus.arb_busy, 0);
    endtask

    task automatic start_hold(output int n);
        int c = 0;
        n = 0;
        while (!bus.uart_start && c < 3000) begin
            tick();
            c++;
        end
        do begin
            @(negedge clk);
            if (bus.uart_start) n++;
        end while (bus.uart_start && n < 3000);
    endtask

    task automatic do_reset();
        int c = 0;
        while (bus.uart_busy && c < 3000) begin
            tick();
            c++;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_uart_start"}, bus.uart_start, 0);
        check({tag, "_uart_data"}, bus.uart_data, 0);
        check({tag, "_grant_id"}, bus.grant_id, 0);
        check({tag, "_arb_busy"}, bus.arb_busy, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        int n;
        int c;
        bus.req_valid = '0;
        bus.req_data  = '0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        // Single requester: ready must appear on the second sampled cycle
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ready == '0 && n < 10);
        check("latency", n, 2);
        wait_grants(1);
        bus.req_valid = '0;
        check("single_grant", g(0), 0);
        wait_idle();
        check("single_data", s(0), 8'hA5);
        // All requesters continuously valid from a fresh pointer
        do_reset();
        grants.delete();
        starts.delete();
        bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid = 4'b1111;
        wait_grants(5);
        bus.req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            check("rr_order", g(i), i % 4);
            check("rr_data", s(i), 8'h10 + i % 4);
        end
        check("one_ready_per_transfer", grants.size(), starts.size());
        // Pointer wrap: grant 3, then 1001 serves 0 before 3
        grants.delete();
        bus.req_valid = 4'b1000;
        wait_grants(1);
        bus.req_valid = '0;
        wait_idle();
        bus.req_valid = 4'b1001;
        wait_grants(2);
        bus.req_valid = 4'b1000;
        wait_grants(3);
        bus.req_valid = '0;
        wait_idle();
        check("wrap_0", g(0), 3);
        check("wrap_1", g(1), 0);
        check("wrap_2", g(2), 3);
        // Slow transmitter: busy appears 500 cycles into the start request
        grants.delete();
        starts.delete();
        rise_delay = 499;
        bus.req_data[23:16] = 8'h5A;
        bus.req_valid = 4'b0100;
        wait_grants(1);
        bus.req_valid = '0;
        bus.req_data[23:16] = 8'hFF;
        start_hold(n);
        check("slow_hold", n, 502);
        check("slow_data", s(0), 8'h5A);
        check("slow_data_end", bus.uart_data, 8'h5A);
        wait_idle();
        rise_delay = 2;
        // Reset while draining; pointer must restart at 0
        busy_len = 20;
        bus.req_data[23:16] = 8'h77;
        bus.req_valid = 4'b0100;
        wait_grants(2);
        bus.req_valid = '0;
        c = 0;
        while (!bus.uart_busy && c < 3000) begin
            tick();
            c++;
        end
        repeat (4) tick();
        check("in_wait_done", bus.arb_busy && !bus.uart_start, 1);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        c = 0;
        while (bus.uart_busy && c < 3000) begin
            tick();
            c++;
        end
        tick();
        rst = 1'b0;
        busy_len = 8;
        grants.delete();
        starts.delete();
        bus.req_data[15:8]  = 8'h31;
        bus.req_data[31:24] = 8'h33;
        bus.req_valid = 4'b1010;
        wait_grants(1);
        bus.req_valid = '0;
        wait_idle();
        check("post_reset_grant", g(0), 1);
        check("post_reset_data", s(0), 8'h31);
`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never answers: start gives up after TO+1 cycles
        tx_en = 1'b0;
        grants.delete();
        starts.delete();
        bus.req_data[7:0] = 8'hEE;
        bus.req_valid = 4'b0001;
        wait_grants(1);
        bus.req_valid = '0;
        start_hold(n);
        check("to_hold", n, TO + 1);
        tick();
        check("to_err", bus.timeout_err, 1);
        check("to_idle", bus.arb_busy, 0);
        tx_en = 1'b1;
        bus.req_data[15:8] = 8'h42;
        bus.req_valid = 4'b0010;
        wait_grants(2);
        bus.req_valid = '0;
        wait_idle();
        check("to_next_grant", g(1), 1);
        check("to_next_data", s(1), 8'h42);
        check("to_err_sticky", bus.timeout_err, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
